// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq -- sequential 16-bit binary to 4-digit packed BCD converter.
//
// Converts one unsigned 16-bit value using the double-dabble algorithm.
// Each conversion runs one iteration per clock, 16 clocks in total.
// A conversion is accepted when the block is IDLE and in_valid is high.
// The result registers (bcd, overflow) change only at completion, so a
// display driven directly from bcd never sees partial scratch values.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   request: bin holds a value to convert
//   in_ready   out  1   IDLE and not in reset (combinational)
//   bin        in  16   unsigned binary value, sampled on acceptance only
//   out_valid  out  1   one-cycle pulse when bcd/overflow were just written
//   bcd        out 16   packed BCD, [15:12] thousands .. [3:0] units
//   overflow   out  1   last converted value was greater than 9999
//
// Build option:
//   BIN2BCD_SATURATE_EN  when defined, an overflowing result writes
//                        bcd = 16'h9999 instead of the value mod 10000.
// -----------------------------------------------------------------------------
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] bin,
    output logic        out_valid,
    output logic [15:0] bcd,
    output logic        overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] bin_q;
    logic [19:0] scr_q;
    logic [15:0] bcd_q;
    logic        ovf_q;
    logic        vld_q;

    logic [19:0] adj;
    logic [19:0] scr_d;
    logic [15:0] bin_d;
    logic        ovf_d;
    logic [15:0] bcd_d;

    // One double-dabble step: correct every digit >= 5, then shift the
    // combined {scratch, binary} register left by one bit.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < 5; i++) begin
            if (scr_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scr_q[i*4 +: 4] + 4'd3;
        end
        {scr_d, bin_d} = {adj[18:0], bin_q, 1'b0};

        // Ten-thousands digit is only non-zero when the input exceeded 9999.
        ovf_d = |scr_d[19:16];
`ifdef BIN2BCD_SATURATE_EN
        bcd_d = ovf_d ? 16'h9999 : scr_d[15:0];
`else
        bcd_d = scr_d[15:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            bin_q   <= 16'd0;
            scr_q   <= 20'd0;
            bcd_q   <= 16'h0000;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bin_q   <= bin;
                        scr_q   <= 20'd0;
                        cnt_q   <= 4'd0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_d;
                    scr_q <= scr_d;
                    cnt_q <= cnt_q + 4'd1;
                    // Counter value 15 means this edge performs iteration 16.
                    if (cnt_q == 4'd15) begin
                        bcd_q   <= bcd_d;
                        ovf_q   <= ovf_d;
                        vld_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = vld_q;
    assign bcd       = bcd_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq -- directed self-checking bench for bin2bcd_seq.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bin;
    logic        out_valid;
    logic [15:0] bcd;
    logic        overflow;

    int checks = 0;
    int errors = 0;

`ifdef BIN2BCD_SATURATE_EN
    localparam logic [15:0] EXP_10000 = 16'h9999;
    localparam logic [15:0] EXP_65535 = 16'h9999;
`else
    localparam logic [15:0] EXP_10000 = 16'h0000;
    localparam logic [15:0] EXP_65535 = 16'h5535;
`endif

    bin2bcd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .bcd       (bcd),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Stimulus helper (no checking). Called at a falling edge with the DUT
    // ready. Presents v for one edge, then scrambles bin while the
    // conversion runs. Returns edges from acceptance to out_valid (-1 on
    // timeout) and the number of cycles in_ready was low. Returns at the
    // falling edge where out_valid is high.
    task automatic run_conv(input logic [15:0] v, output int lat, output int rdy_low);
        in_valid = 1'b1;
        bin      = v;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = -1;
        rdy_low  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid) begin
                lat = k - 1;
                break;
            end
            if (!in_ready) rdy_low++;
            bin = ~bin ^ 16'(k);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        bin      = 16'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        checks++;
        if ({out_valid, overflow, bcd} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b overflow=%b bcd=%h want 0 0 0000",
                     out_valid, overflow, bcd);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_zero;
        int lat, rl;
        run_conv(16'd0, lat, rl);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL zero_latency: got %0d want 16", lat);
        end
        checks++;
        if ({overflow, bcd} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL zero_result: overflow=%b bcd=%h want 0 0000", overflow, bcd);
        end
        @(negedge clk);
    endtask

    task automatic test_1234;
        int lat, rl;
        run_conv(16'd1234, lat, rl);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL 1234_latency: got %0d want 16", lat);
        end
        checks++;
        if (rl !== 16) begin
            errors++;
            $display("FAIL 1234_ready_low: got %0d cycles want 16", rl);
        end
        checks++;
        if ({overflow, bcd} !== {1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL 1234_result: overflow=%b bcd=%h want 0 1234", overflow, bcd);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL 1234_pulse_width: out_valid=%b want 0", out_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, bcd} !== {1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL 1234_hold: out_valid=%b bcd=%h want 0 1234", out_valid, bcd);
        end
    endtask

    task automatic test_boundaries;
        logic [15:0] vin [3]  = '{16'd9999, 16'd10000, 16'd65535};
        logic [15:0] vbcd [3] = '{16'h9999, EXP_10000, EXP_65535};
        logic        vovf [3] = '{1'b0, 1'b1, 1'b1};
        int lat, rl;
        for (int i = 0; i < 3; i++) begin
            run_conv(vin[i], lat, rl);
            checks++;
            if (lat !== 16 || bcd !== vbcd[i] || overflow !== vovf[i]) begin
                errors++;
                $display("FAIL boundary_%0d: lat=%0d bcd=%h ovf=%b want 16 %h %b",
                         vin[i], lat, bcd, overflow, vbcd[i], vovf[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_busy;
        int lat;
        in_valid = 1'b1;
        bin      = 16'd100;
        @(negedge clk);
        // Keep requesting a different value while busy; must be ignored.
        bin = 16'd200;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int k = 9; k <= 40; k++) begin
            if (out_valid) begin
                lat = k - 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat !== 16 || bcd !== 16'h0100) begin
            errors++;
            $display("FAIL ignore_busy: lat=%0d bcd=%h want 16 0100", lat, bcd);
        end
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL ignore_no_queue: got %0d extra pulses want 0", lat);
        end
    endtask

    task automatic test_back_to_back;
        int lat, rl;
        run_conv(16'd42, lat, rl);
        checks++;
        if (lat !== 16 || bcd !== 16'h0042) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d bcd=%h want 16 0042", lat, bcd);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_on_valid: got %b want 1", in_ready);
        end
        // Present the next request in the out_valid cycle.
        run_conv(16'd7, lat, rl);
        checks++;
        if (lat + 1 !== 17 || bcd !== 16'h0007) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d bcd=%h want 17 0007", lat + 1, bcd);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int lat, rl, pulses;
        in_valid = 1'b1;
        bin      = 16'd5678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        // Reset also competes with a request; reset must win.
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, overflow, bcd} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL abort_state: ready=%b vld=%b ovf=%b bcd=%h want 1 0 0 0000",
                     in_ready, out_valid, overflow, bcd);
        end
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d pulses want 0", pulses);
        end
        run_conv(16'd5678, lat, rl);
        checks++;
        if (lat !== 16 || bcd !== 16'h5678 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort_recover: lat=%0d bcd=%h ovf=%b want 16 5678 0",
                     lat, bcd, overflow);
        end
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        bin      = 16'd0;
        @(negedge clk);
        test_reset();
        test_zero();
        test_1234();
        test_boundaries();
        test_ignore_busy();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request: bin holds a value to convert.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 bin  input  16  unsigned binary value, sampled only on acceptance.
REQ-007 out_valid  output  1  one-cycle pulse: bcd/overflow just updated.
REQ-008 bcd  output  16  four packed BCD digits, [15:12] thousands .. [3:0] units; feeds the 4-digit seven-segment driver data input directly.
REQ-009 overflow  output  1  last converted value exceeded 9999.

Function
REQ-010 FSM states: IDLE, SHIFT; one-hot or binary encoding is implementer's choice.
REQ-011 in_ready SHALL be 1 exactly when state is IDLE and rst is 0; it is a combinational decode of state.
REQ-012 Acceptance: rising edge with in_valid=1 and in_ready=1. bin is captured into a 16-bit shift register, the 20-bit (5-digit) BCD scratch register is cleared, the iteration counter is cleared, and the state goes to SHIFT.
REQ-013 in_valid while in_ready=0 SHALL be ignored, with no queuing; bin changes after acceptance SHALL have no effect.
REQ-014 SHIFT performs one double-dabble iteration per cycle, 16 iterations total:
  - add 3 to each scratch nibble >= 5;
  - shift {scratch, binreg} left by 1.
REQ-015 Iteration counter: 4 bits, increments each SHIFT cycle. The edge completing iteration 16 (counter==15) SHALL:
  - write bcd and overflow;
  - set out_valid=1;
  - return the state to IDLE.
REQ-016 Latency: acceptance at edge E0 -> bcd/overflow updated at edge E16. out_valid is high only in the cycle between E16 and E17. in_ready is low for exactly 16 cycles per conversion.
REQ-017 out_valid SHALL be 0 in every other cycle, including cycles with no conversion in progress.
REQ-018 bcd and overflow SHALL hold their last written value until the next completion; the display must never see intermediate scratch values.
REQ-019 overflow = 1 iff the final scratch ten-thousands digit (bits [19:16]) is non-zero, i.e. bin > 9999. Otherwise overflow = 0 and bcd = scratch[15:0].
REQ-020 A new request SHALL be accepted in the same cycle that out_valid is high, since the state is already IDLE. Back-to-back throughput is one result per 17 cycles.
REQ-021 A completion and an acceptance at the same edge SHALL be impossible by construction, because acceptance requires IDLE.

Reset
REQ-022 On a rising edge with rst=1, the block SHALL:
  - set state to IDLE;
  - clear bcd to 16'h0000, overflow to 0, out_valid to 0;
  - clear the counter, shift and scratch registers.
REQ-023 rst asserted during SHIFT SHALL abort the conversion: no out_valid, bcd reads 0 from the next cycle, and in_ready=1 in the first cycle after rst deasserts.
REQ-024 rst has priority over acceptance and completion on the same edge.

Configuration
REQ-025 Macro BIN2BCD_SATURATE_EN.
  - Defined: when overflow=1, bcd SHALL be written 16'h9999.
  - Not defined: when overflow=1, bcd SHALL be written scratch[15:0] (value mod 10000).
  - overflow behaviour is identical in both builds.

Verification
REQ-026 Reset, then bin=16'd0 accepted -> out_valid at E16, bcd=16'h0000, overflow=0.
REQ-027 bin=16'd1234 (0x04D2) accepted -> in_ready low 16 cycles, bcd=16'h1234 at E16, out_valid high exactly one cycle.
REQ-028 bin=16'd9999 -> bcd=16'h9999, overflow=0. bin=16'd10000 -> overflow=1, bcd=16'h9999 (macro) / 16'h0000 (no macro).
REQ-029 bin=16'd65535 -> overflow=1, bcd=16'h9999 with BIN2BCD_SATURATE_EN, 16'h5535 without.
REQ-030 bin=42 accepted, then bin=7 presented in the out_valid cycle -> bcd=16'h0042, then 16'h0007 exactly 17 cycles later. bin toggled mid-SHIFT does not change the result.
REQ-031 bin=16'd5678 accepted, rst pulsed at iteration 8 -> no out_valid, bcd=0, in_ready=1 the cycle after rst falls. A following request converts correctly.
